// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the receive front end, and
// later for the TX path.
package uart_pkg;

  // Data bits per frame; frames are LSB first on the wire.
  localparam int UART_DATA_BITS = 8;

  // 100 MHz system clock at 115200 baud.
  localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

  // Receive FSM states. PARITY is only reachable when parity checking is built in.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs. Its width and reset
// value are parameters so the TX path and the GPIO inputs can reuse it.
module sync_2ff #(
  parameter int                WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops. meta may go metastable; q is the settled copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: UART receive front end. It synchronises the rx pin,
// validates the start bit, samples each bit at mid-bit and presents every byte
// on a one-entry valid/ready output register. Framing and overrun errors are
// reported as one-cycle pulses.
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames and get a
// parity_err pulse. Without it the frame is 8N1 and parity_err is tied low.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(HALF_BIT - 1);
  localparam int                IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  rx_state_t                 state;
  rx_state_t                 state_next;
  logic                      rx_s;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      bit_tick;
  logic                      shift_en;
  logic                      stop_ok;
  logic                      stop_bad;
  logic                      byte_done;
`ifdef UART_RX_PARITY_EN
  logic                      par_bit;
  logic                      par_sample;
`endif

  // The rx pin idles high, so the synchroniser resets to 1 to avoid a false start.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign bit_tick = (cnt == CNT_LAST);
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the per-state sample strobes.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
        end
      end
      START: begin
        if (cnt == CNT_MID) begin
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_en = 1'b1;
          if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          par_sample = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (rx_s) begin
            stop_ok    = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bit-period counter: restarts on every state change and wraps once per bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state_next != state) || (state == IDLE) || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Data shift register and bit index. Bits arrive LSB first, so shift right.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if ((state != DATA) && (state_next == DATA)) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + IDX_W'(1);
      end
      if (shift_en) begin
        shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Received parity bit, held until the stop bit decides whether the byte completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (par_sample) begin
      par_bit <= rx_s;
    end
  end

  // Even-parity check, reported in the completion cycle of a well-framed byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= stop_ok && (^{shreg, par_bit});
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Completion marker and framing-error pulse, one cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_done <= stop_ok;
      frame_err <= stop_bad;
    end
  end

  // One-entry output register. A completing byte may replace a byte that is
  // being accepted in the same cycle; otherwise it is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (byte_done) begin
        if (!out_valid || out_ready) begin
          out_data  <= shreg;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed frames into uart_rx_frontend with a frame-level
// reference model checked every cycle, plus literal expectations per scenario.
// Build with UART_RX_PARITY_EN defined to include the parity scenario.
module tb_uart_rx_frontend;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  // Clock edges from the edge after rx falls to the stop-bit sample edge:
  // 2 synchroniser flops, 1 detect cycle, half a start bit, then data/parity/stop.
  localparam int LAT = 3 + HALF + NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  uart_rx_frontend #(
    .CLKS_PER_BIT (CPB),
    .HALF_BIT     (HALF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Scheduled frames, written by the stimulus and consumed by the model.
  int         fr_e0   [64];
  logic [7:0] fr_data [64];
  logic       fr_fbad [64];
  logic       fr_pbad [64];
  int         fr_wr = 0;
  int         fr_rd = 0;

  // Reference model state.
  int         cyc = 0;
  logic       mv = 1'b0;
  logic [7:0] md = 8'h00;
  logic       e_fe = 1'b0;
  logic       e_ov = 1'b0;
  logic       e_pe = 1'b0;
  logic       pend = 1'b0;
  logic [7:0] pend_data = 8'h00;

  // Literal expectations posted by the stimulus, checked by the compare process.
  string      lit_name [256];
  logic [7:0] lit_act  [256];
  logic [7:0] lit_exp  [256];
  int         lit_wr = 0;
  int         lit_rd = 0;

  // Counters owned by the compare process.
  int tests_run = 0;
  int tests_failed = 0;
  int vcnt = 0;
  int fecnt = 0;
  int ovcnt = 0;
  int pecnt = 0;

  // Frame-level model: a byte completes one edge after its stop sample and is
  // accepted into the output register unless a full register is not being read.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (rst) begin
      mv    = 1'b0;
      md    = 8'h00;
      e_fe  = 1'b0;
      e_ov  = 1'b0;
      e_pe  = 1'b0;
      pend  = 1'b0;
      fr_rd = fr_wr;
    end else begin
      e_fe = 1'b0;
      e_ov = 1'b0;
      e_pe = 1'b0;
      if (pend) begin
        if (!mv || out_ready) begin
          mv = 1'b1;
          md = pend_data;
        end else begin
          e_ov = 1'b1;
        end
      end else if (mv && out_ready) begin
        mv = 1'b0;
      end
      pend = 1'b0;
      if ((fr_rd < fr_wr) && (fr_e0[fr_rd] == cyc)) begin
        if (fr_fbad[fr_rd]) begin
          e_fe = 1'b1;
        end else begin
          pend      = 1'b1;
          pend_data = fr_data[fr_rd];
          e_pe      = fr_pbad[fr_rd];
        end
        fr_rd = fr_rd + 1;
      end
    end
  end

  task automatic doCompare(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run = tests_run + 1;
    if (act !== exp) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: DUT against the model every cycle, then any posted literals.
  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      doCompare("out_valid", 8'(out_valid), 8'(mv));
      if (mv) begin
        doCompare("out_data", out_data, md);
      end
      doCompare("frame_err", 8'(frame_err), 8'(e_fe));
      doCompare("overrun", 8'(overrun), 8'(e_ov));
      doCompare("parity_err", 8'(parity_err), 8'(e_pe));
      if (out_valid === 1'b1) vcnt = vcnt + 1;
      if (frame_err === 1'b1) fecnt = fecnt + 1;
      if (overrun === 1'b1) ovcnt = ovcnt + 1;
      if (parity_err === 1'b1) pecnt = pecnt + 1;
    end
    while (lit_rd < lit_wr) begin
      doCompare(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
      lit_rd = lit_rd + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    if (lit_wr < 256) begin
      lit_name[lit_wr] = name;
      lit_act[lit_wr]  = act;
      lit_exp[lit_wr]  = exp;
      lit_wr = lit_wr + 1;
    end
  endtask

  // Drive one frame on rx and schedule its expected outcome for the model.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    logic pbit;
    logic pbad;
`ifdef UART_RX_PARITY_EN
    pbit = (^data) ^ par_flip;
    pbad = ^{data, pbit};
`else
    pbit = 1'b0;
    pbad = 1'b0;
`endif
    fr_e0[fr_wr]   = cyc + LAT;
    fr_data[fr_wr] = data;
    fr_fbad[fr_wr] = !stop_bit;
    fr_pbad[fr_wr] = pbad;
    fr_wr = fr_wr + 1;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = pbit;
    tick(CPB);
`endif
    rx = stop_bit;
    tick(CPB);
  endtask

  int vb, fb, ob, pb;
  int t1;
  int n;

  task automatic snap();
    vb = vcnt;
    fb = fecnt;
    ob = ovcnt;
    pb = pecnt;
  endtask

  initial begin
    tick(3);
    checkOutput("rst_out_valid", 8'(out_valid), 8'd0);
    checkOutput("rst_out_data", out_data, 8'h00);
    checkOutput("rst_frame_err", 8'(frame_err), 8'd0);
    checkOutput("rst_overrun", 8'(overrun), 8'd0);
    checkOutput("rst_parity_err", 8'(parity_err), 8'd0);
    checkOutput("rst_busy", 8'(busy), 8'd0);
    rst = 1'b0;
    tick(5);

    // Frame 0xA5 with out_ready held high.
    out_ready = 1'b1;
    snap();
    applyStimulus(8'hA5, 1'b1);
    tick(20);
    checkOutput("a5_valid_cycles", 8'(vcnt - vb), 8'd1);
    checkOutput("a5_data", out_data, 8'hA5);
    checkOutput("a5_frame_err", 8'(fecnt - fb), 8'd0);
    checkOutput("a5_overrun", 8'(ovcnt - ob), 8'd0);
    checkOutput("a5_busy_after", 8'(busy), 8'd0);

    // Three-cycle low glitch on rx.
    snap();
    rx = 1'b0;
    tick(3);
    checkOutput("glitch_start_busy", 8'(busy), 8'd1);
    rx = 1'b1;
    tick(15);
    checkOutput("glitch_valid_cycles", 8'(vcnt - vb), 8'd0);
    checkOutput("glitch_busy_after", 8'(busy), 8'd0);

    // Frame 0x3C with a low stop bit, then a good 0x55.
    snap();
    applyStimulus(8'h3C, 1'b0);
    checkOutput("fe_wait_idle_busy", 8'(busy), 8'd1);
    rx = 1'b1;
    tick(20);
    checkOutput("fe_pulses", 8'(fecnt - fb), 8'd1);
    checkOutput("fe_valid_cycles", 8'(vcnt - vb), 8'd0);
    checkOutput("fe_busy_after", 8'(busy), 8'd0);
    snap();
    applyStimulus(8'h55, 1'b1);
    tick(20);
    checkOutput("after_fe_valid_cycles", 8'(vcnt - vb), 8'd1);
    checkOutput("after_fe_data", out_data, 8'h55);
    checkOutput("after_fe_frame_err", 8'(fecnt - fb), 8'd0);

    // 0x11 then 0x22 with nobody reading.
    out_ready = 1'b0;
    snap();
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    tick(5);
    checkOutput("ovr_pulses", 8'(ovcnt - ob), 8'd1);
    checkOutput("ovr_valid", 8'(out_valid), 8'd1);
    checkOutput("ovr_data_kept", out_data, 8'h11);
    out_ready = 1'b1;
    tick(1);
    checkOutput("ovr_drain_valid", 8'(out_valid), 8'd0);
    out_ready = 1'b0;
    tick(5);

    // out_ready only in the completion cycle of 0x22 while 0x11 is pending.
    snap();
    applyStimulus(8'h11, 1'b1);
    t1 = cyc;
    fork
      applyStimulus(8'h22, 1'b1);
      begin
        n = 0;
        while ((cyc < t1 + LAT) && (n < 500)) begin
          tick(1);
          n = n + 1;
        end
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
      end
    join
    tick(5);
    checkOutput("swap_overrun", 8'(ovcnt - ob), 8'd0);
    checkOutput("swap_valid", 8'(out_valid), 8'd1);
    checkOutput("swap_data", out_data, 8'h22);
    out_ready = 1'b1;
    tick(2);
    checkOutput("swap_drain_valid", 8'(out_valid), 8'd0);

    // Reset pulse in the middle of the data bits of 0xFF.
    snap();
    fork
      applyStimulus(8'hFF, 1'b1);
      begin
        tick(30);
        checkOutput("mid_frame_busy", 8'(busy), 8'd1);
        rst = 1'b1;
        tick(1);
        checkOutput("midrst_valid", 8'(out_valid), 8'd0);
        checkOutput("midrst_data", out_data, 8'h00);
        checkOutput("midrst_frame_err", 8'(frame_err), 8'd0);
        checkOutput("midrst_overrun", 8'(overrun), 8'd0);
        checkOutput("midrst_busy", 8'(busy), 8'd0);
        rst = 1'b0;
      end
    join
    tick(20);
    checkOutput("midrst_valid_cycles", 8'(vcnt - vb), 8'd0);
    checkOutput("midrst_fe_pulses", 8'(fecnt - fb), 8'd0);
    snap();
    applyStimulus(8'h81, 1'b1);
    tick(20);
    checkOutput("post_rst_valid_cycles", 8'(vcnt - vb), 8'd1);
    checkOutput("post_rst_data", out_data, 8'h81);

`ifdef UART_RX_PARITY_EN
    // 0x07 with parity bit 0: odd total, so the check must fire.
    snap();
    par_flip = 1'b1;
    applyStimulus(8'h07, 1'b1);
    par_flip = 1'b0;
    tick(20);
    checkOutput("par_pulses", 8'(pecnt - pb), 8'd1);
    checkOutput("par_data", out_data, 8'h07);
    checkOutput("par_valid_cycles", 8'(vcnt - vb), 8'd1);
`endif
    checkOutput("total_parity_pulses", 8'(pecnt - pb),
`ifdef UART_RX_PARITY_EN
                8'd1);
`else
                8'd0);
`endif

    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Serial-to-parallel receive stage between the SoC uart_rx pin and the UART controller's receive buffer.
- Synchronises the asynchronous rx line and detects and validates the start bit.
- Samples 8N1 frames at mid-bit, then presents each byte on a one-entry valid/ready output register.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); legal range is 4 or more.
- HALF_BIT, CLKS_PER_BIT/2 (floor), cycle offset from the start-bit falling edge to the start-bit sample point.

Ports:
- clk  input  1  system clock
- rst  input  1  reset: synchronous, active-high
- rx  input  1  asynchronous serial line; idles high
- out_data  output  8  received byte, LSB first on the wire
- out_valid  output  1  out_data holds an unconsumed byte
- out_ready  input  1  consumer accepts the byte when out_valid && out_ready at a clock edge
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: a new byte completed while the output register was full and not being accepted
- parity_err  output  1  one-cycle pulse; tied 0 unless UART_RX_PARITY_EN is defined
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset values: out_data=0, out_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0. Synchroniser flops reset to 1. FSM resets to IDLE and the bit counter to 0.
- Synchroniser: 2 flops. rx_s is rx delayed by 2 cycles. All FSM decisions use rx_s.
- Bit-timing counter cnt: counts 0..CLKS_PER_BIT-1 and wraps to 0; it is cleared on every state entry.
- FSM states: IDLE, START, DATA, PARITY (exists only with the macro), STOP, WAIT_IDLE.
  - IDLE: rx_s==0 moves to START with cnt=0.
  - START: at cnt==HALF_BIT-1, if rx_s==1 (glitch) return to IDLE with no output. Otherwise go to DATA with cnt=0 and bit index=0.
  - DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into shreg[7] (right shift, LSB first) and increment the bit index. After bit 7, go to PARITY if enabled, else STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - Sample 1: the byte completes and the FSM goes to IDLE.
    - Sample 0: pulse frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. This handles break conditions.
- Byte completion (the cycle after the stop sample):
  - If out_valid==0, or out_valid && out_ready in the same cycle: load out_data and set out_valid=1.
  - Otherwise: pulse overrun, drop the new byte, and keep the old out_data and out_valid.
- Handshake: out_valid && out_ready with no completion in the same cycle clears out_valid on the next edge. out_data is stable while out_valid=1.
- Latency: about 9.5 bit periods from the rx falling edge to out_valid rising, plus 2 synchroniser cycles and 1 register cycle.
- Reset mid-frame: the FSM aborts to IDLE, any partial byte is lost, and no error pulse is generated.
- Error pulses are exactly one cycle wide and never assert during reset.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - The PARITY state follows DATA and lasts one bit period.
  - The bit is sampled at cnt==CLKS_PER_BIT-1 and checked for even parity: XOR of 8 data bits and the parity bit must equal 0.
  - On a mismatch, parity_err pulses in the completion cycle. The byte is still delivered, subject to the overrun rules.
- When undefined: there is no PARITY state, the frame is 8N1, and parity_err is constant 0.

Decomposition:
- Package uart_pkg:
  - rx state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE).
  - UART_DATA_BITS=8.
  - Default CLKS_PER_BIT constant.
- Sub-module sync_2ff: parameterised-width two-flop synchroniser with a reset value parameter. It is reused later by the TX path and by the GPIO inputs.

Test Plan:
- All scenarios use CLKS_PER_BIT=8.
- Frame 0xA5 with out_ready held high -> out_valid pulses 1 cycle, out_data=0xA5, no errors, busy low afterwards.
- rx low for 3 cycles then high -> no START acceptance, out_valid stays 0, FSM returns to IDLE.
- Frame 0x3C with stop bit driven 0, then rx high -> frame_err one pulse, out_valid stays 0. A following frame 0x55 is received correctly.
- Frames 0x11 then 0x22 with out_ready=0 -> overrun pulses once and out_data stays 0x11. Raising out_ready then clears out_valid.
- out_ready asserted in the exact completion cycle of 0x22 while 0x11 is pending -> 0x11 is consumed, 0x22 loads, no overrun.
- rst asserted for 1 cycle mid-DATA of 0xFF -> all outputs are 0 and no byte is delivered. The next frame 0x81 is received correctly.
- With UART_RX_PARITY_EN, 0x07 sent with parity bit 0 -> out_data=0x07 and parity_err pulses once.
